kamacore_writeback_arbiter: RTL and testbench

KAMACORE_WRITEBACK_ARBITER -- requirements
Module: kamacore_writeback_arbiter

---
 rtl/kamacore_writeback_arbiter_pkg.sv | 31 +++
 rtl/kamacore_writeback_arbiter_if.sv | 37 +++
 rtl/kamacore_wb_slot.sv | 35 +++
 rtl/kamacore_writeback_arbiter.sv | 117 +++++++++++
 tb/tb_kamacore_writeback_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/kamacore_writeback_arbiter_pkg.sv
// Shared kamacore constants and types for the writeback path:
// datapath widths, the holding-slot record and arbitration state encodings.
package kamacore_writeback_arbiter_pkg;

   localparam int unsigned CPU_WIDTH      = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned REG_COUNT      = 2 ** REG_ADDR_WIDTH;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [CPU_WIDTH-1:0]      data;
   } slot_t;

   // Relative age of the two slots; only meaningful while both are occupied.
   typedef enum logic [1:0] {
      AGE_ALU_OLDER = 2'd0,
      AGE_LSU_OLDER = 2'd1,
      AGE_TIE       = 2'd2
   } age_t;

   typedef enum logic {
      RR_ALU = 1'b0,
      RR_LSU = 1'b1
   } rr_t;

   function automatic logic [REG_COUNT-1:0] slot_decode(input slot_t s);
      slot_decode = s.valid ? (REG_COUNT'(1) << s.rd) : '0;
   endfunction

endpackage

// File: rtl/kamacore_writeback_arbiter_if.sv
// Writeback bus: ALU and LSU result ports plus the register-file write port.
interface kamacore_writeback_arbiter_if;
   import kamacore_writeback_arbiter_pkg::*;

   logic                      alu_valid;
   logic                      alu_ready;
   logic [REG_ADDR_WIDTH-1:0] alu_rd;
   logic [CPU_WIDTH-1:0]      alu_data;

   logic                      lsu_valid;
   logic                      lsu_ready;
   logic [REG_ADDR_WIDTH-1:0] lsu_rd;
   logic [CPU_WIDTH-1:0]      lsu_data;

   logic                      destination_we;
   logic [REG_ADDR_WIDTH-1:0] destination_a;
   logic [CPU_WIDTH-1:0]      destination_data;
   logic [REG_COUNT-1:0]      pending_mask;
   logic [31:0]               retire_count;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  alu_ready, lsu_ready,
      input  destination_we, destination_a, destination_data,
      input  pending_mask, retire_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output alu_ready, lsu_ready,
      output destination_we, destination_a, destination_data,
      output pending_mask, retire_count
   );

endinterface

// File: rtl/kamacore_wb_slot.sv
// One-entry holding register for a writeback source; ready while empty or
// being drained, so a granted slot can be refilled in the same cycle.
module kamacore_wb_slot
   import kamacore_writeback_arbiter_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   input  logic [CPU_WIDTH-1:0]      in_data,
   input  logic                      grant,
   output logic                      ready,
   output logic                      fire,
   output slot_t                     slot
);

   slot_t slot_q;

   assign ready = !slot_q.valid || grant;
   assign fire  = in_valid && ready;
   assign slot  = slot_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_q <= '0;
      end else if (fire) begin
         slot_q.valid <= 1'b1;
         slot_q.rd    <= in_rd;
         slot_q.data  <= in_data;
      end else if (grant) begin
         slot_q.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/kamacore_writeback_arbiter.sv
// Two-source writeback arbiter: oldest held result wins the register-file port,
// same-edge arrivals are split by a round-robin bit.
module kamacore_writeback_arbiter
   import kamacore_writeback_arbiter_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   kamacore_writeback_arbiter_if.slave   bus
);

   slot_t       alu_slot, lsu_slot;
   logic        alu_fire, lsu_fire;
   logic        grant_alu, grant_lsu;
   logic        alu_occ_n, lsu_occ_n;
   age_t        age_q, age_n;
   rr_t         rr_q, rr_n;
   logic [31:0] retire_q;

   kamacore_wb_slot u_alu_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.alu_valid),
      .in_rd    (bus.alu_rd),
      .in_data  (bus.alu_data),
      .grant    (grant_alu),
      .ready    (bus.alu_ready),
      .fire     (alu_fire),
      .slot     (alu_slot)
   );

   kamacore_wb_slot u_lsu_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.lsu_valid),
      .in_rd    (bus.lsu_rd),
      .in_data  (bus.lsu_data),
      .grant    (grant_lsu),
      .ready    (bus.lsu_ready),
      .fire     (lsu_fire),
      .slot     (lsu_slot)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         age_q <= AGE_ALU_OLDER;
         rr_q  <= RR_ALU;
      end else begin
         age_q <= age_n;
         rr_q  <= rr_n;
      end
   end

   always_comb begin
      age_n     = age_q;
      rr_n      = rr_q;
      grant_alu = 1'b0;
      grant_lsu = 1'b0;

      if (alu_slot.valid && lsu_slot.valid) begin
         unique case (age_q)
            AGE_TIE: begin
               grant_alu = (rr_q == RR_ALU);
               grant_lsu = (rr_q == RR_LSU);
               rr_n      = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;
            end
            AGE_LSU_OLDER: grant_lsu = 1'b1;
            default:       grant_alu = 1'b1;
         endcase
      end else if (alu_slot.valid) begin
         grant_alu = 1'b1;
      end else if (lsu_slot.valid) begin
         grant_lsu = 1'b1;
      end

      // Age is re-derived from what each slot holds after this edge: a fresh
      // capture is always younger than a slot that merely kept its entry.
      alu_occ_n = alu_fire || (alu_slot.valid && !grant_alu);
      lsu_occ_n = lsu_fire || (lsu_slot.valid && !grant_lsu);
      if (alu_occ_n && lsu_occ_n) begin
         if (alu_fire && lsu_fire)
            age_n = AGE_TIE;
         else if (alu_fire)
            age_n = AGE_LSU_OLDER;
         else if (lsu_fire)
            age_n = AGE_ALU_OLDER;
      end else begin
         age_n = AGE_ALU_OLDER;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         retire_q <= '0;
      else if (grant_alu || grant_lsu)
         retire_q <= retire_q + 32'd1;
   end

   always_comb begin
      bus.destination_we   = 1'b0;
      bus.destination_a    = '0;
      bus.destination_data = '0;
      if (rst && grant_alu) begin
         bus.destination_we   = 1'b1;
         bus.destination_a    = alu_slot.rd;
         bus.destination_data = alu_slot.data;
      end else if (rst && grant_lsu) begin
         bus.destination_we   = 1'b1;
         bus.destination_a    = lsu_slot.rd;
         bus.destination_data = lsu_slot.data;
      end
   end

   // Visible state reads as cleared for the whole cycle rst is held low.
   assign bus.pending_mask = rst ? (slot_decode(alu_slot) | slot_decode(lsu_slot)) : '0;
   assign bus.retire_count = rst ? retire_q : '0;

endmodule

// File: tb/tb_kamacore_writeback_arbiter.sv
// Scoreboard bench for the writeback arbiter: a timestamp-based reference model
// predicts writes, a separate monitor pops and compares them.
module tb_kamacore_writeback_arbiter;
   import kamacore_writeback_arbiter_pkg::*;

   typedef struct {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [CPU_WIDTH-1:0]      data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   kamacore_writeback_arbiter_if bus ();

   kamacore_writeback_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   exp_t        exp_q[$];

   // Reference model: each source holds at most one entry stamped with the
   // edge number it arrived on; the smallest stamp is written first.
   bit                        occ   [2];
   logic [REG_ADDR_WIDTH-1:0] m_rd  [2];
   logic [CPU_WIDTH-1:0]      m_dat [2];
   int unsigned               stamp [2];
   bit                        rr_to_lsu;
   int unsigned               t_now;
   logic [31:0]               m_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      occ[0] = 0; occ[1] = 0;
      rr_to_lsu = 0;
      m_count = '0;
   endtask

   task automatic cycle(input bit av, input logic [REG_ADDR_WIDTH-1:0] ard, input logic [CPU_WIDTH-1:0] ad,
                        input bit lv, input logic [REG_ADDR_WIDTH-1:0] lrd, input logic [CPU_WIDTH-1:0] ld,
                        input bit rn);
      int g;
      bit ra, rl, tie;
      logic [REG_COUNT-1:0] emask;
      exp_t e;
      @(negedge clk);
      rst           = rn;
      bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = ad;
      bus.lsu_valid = lv;  bus.lsu_rd = lrd; bus.lsu_data = ld;
      #1;
      g = -1; ra = 0; rl = 0; tie = 0;
      if (rn) begin
         if (occ[0] && occ[1]) begin
            tie = (stamp[0] == stamp[1]);
            if (stamp[0] < stamp[1])      g = 0;
            else if (stamp[1] < stamp[0]) g = 1;
            else                          g = rr_to_lsu ? 1 : 0;
         end else if (occ[0]) g = 0;
         else if (occ[1])     g = 1;
         ra = !occ[0] || g == 0;
         rl = !occ[1] || g == 1;
         check("alu_ready", 32'(bus.alu_ready), 32'(ra));
         check("lsu_ready", 32'(bus.lsu_ready), 32'(rl));
         emask = '0;
         for (int i = 0; i < 2; i++) if (occ[i]) emask[m_rd[i]] = 1'b1;
         check("pending_mask", bus.pending_mask, emask);
         check("retire_count", bus.retire_count, m_count);
         if (g >= 0) begin
            e.rd = m_rd[g]; e.data = m_dat[g];
            exp_q.push_back(e);
         end
      end else begin
         check("pending_in_reset", bus.pending_mask, '0);
         check("retire_in_reset", bus.retire_count, '0);
      end
      @(posedge clk);
      if (!rn) begin
         model_clear();
      end else begin
         if (g >= 0) begin
            if (tie) rr_to_lsu = (g == 0);
            occ[g] = 0;
            m_count = m_count + 32'd1;
         end
         t_now++;
         if (av && ra) begin occ[0] = 1; m_rd[0] = ard; m_dat[0] = ad; stamp[0] = t_now; end
         if (lv && rl) begin occ[1] = 1; m_rd[1] = lrd; m_dat[1] = ld; stamp[1] = t_now; end
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, 1);
   endtask

   // Monitor: every cycle either consumes exactly the predicted write or sees none.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.destination_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: got a=%0d data=%h expected no write at %0t",
                        bus.destination_a, bus.destination_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("dest_a", 32'(bus.destination_a), 32'(e.rd));
               check("dest_data", bus.destination_data, e.data);
            end
         end else begin
            check("idle_a", 32'(bus.destination_a), '0);
            check("idle_data", bus.destination_data, '0);
         end
         if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL missing_write: got we=%b expected write of %0d entries at %0t",
                     bus.destination_we, exp_q.size(), $time);
            exp_q.delete();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
      t_now = 0;
      model_clear();
      for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, '0, '0, 0);

      // Single ALU write
      cycle(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, 1);
      idle(2);
      #2 check("single_retire", bus.retire_count, 32'd1);

      // Two same-edge ties: ALU first, then LSU first
      cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1);
      idle(3);
      cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1);
      idle(3);

      // Equal rd written in age order
      cycle(0, '0, '0, 1, 5'd7, 32'hAA, 1);
      cycle(1, 5'd7, 32'hBB, 0, '0, '0, 1);
      idle(2);

      // Reset with both slots full
      cycle(1, 5'd1, 32'h100, 1, 5'd2, 32'h200, 1);
      cycle(1, 5'd3, 32'h300, 1, 5'd4, 32'h400, 1);
      cycle(1, 5'd9, 32'h999, 1, 5'd9, 32'h999, 0);
      #2;
      check("post_reset_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("post_reset_lsu_ready", 32'(bus.lsu_ready), 32'd1);
      check("post_reset_retire", bus.retire_count, 32'd0);
      check("post_reset_pending", bus.pending_mask, '0);

      // Streaming ALU
      for (int i = 0; i < 10; i++) cycle(1, 5'(i + 10), 32'hC000_0000 + 32'(i), 0, '0, '0, 1);
      idle(2);
      #2 check("stream_retire", bus.retire_count, 32'd10);

      // Counter wrap
      #1 force dut.retire_q = 32'hFFFF_FFFF;
      #1 release dut.retire_q;
      m_count = 32'hFFFF_FFFF;
      cycle(0, '0, '0, 1, 5'd0, 32'h1234_5678, 1);
      idle(2);
      #2 check("wrap_retire", bus.retire_count, 32'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 99) != 0));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
